// File: rtl/esquema_final_pkg.sv
// esquema_final_pkg
// Shared declarations for the ATM session controller: FSM state encoding,
// data width, retry limit, inactivity timeout and a saturating timer helper.
package esquema_final_pkg;

  localparam int WIDTH = 4;

  // Wrong-PIN attempts allowed before the card is ejected.
  localparam logic [1:0] MAX_TRIES = 2'd3;

  // Inactivity timer ceiling; reaching it ejects the card.
  localparam logic [8:0] TIMEOUT = 9'd511;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PIN_ENTRY = 3'd1,
    MENU      = 3'd2,
    PAY       = 3'd3,
    EJECT     = 3'd4
  } state_e;

  // Timer increment that sticks at TIMEOUT instead of wrapping.
  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    logic [8:0] r;
    if (v == TIMEOUT) begin
      r = v;
    end else begin
      r = v + 9'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/esquema_final_debit.sv
// debit_adder
// 4-bit ripple-carry subtractor used to debit the balance.
// Computes {cout_o, diff_o} = bal_i + ~val_i + cin_i; with cin_i = 1 this is
// bal_i - val_i and cout_o = 1 means no borrow (bal_i >= val_i).
// Ports:
//   bal_i  [WIDTH-1:0] current balance
//   val_i  [WIDTH-1:0] requested amount
//   cin_i              carry-in
//   diff_o [WIDTH-1:0] difference
//   cout_o             carry-out
module debit_adder
  import esquema_final_pkg::*;
(
  input  logic [WIDTH-1:0] bal_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] val_n_s;
  logic [WIDTH:0]   carry_s;

  assign val_n_s = ~val_i;

  // Full-adder chain, LSB first.
  always_comb begin
    carry_s    = '0;
    diff_o     = '0;
    carry_s[0] = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      diff_o[i]    = bal_i[i] ^ val_n_s[i] ^ carry_s[i];
      carry_s[i+1] = (bal_i[i] & val_n_s[i]) | (carry_s[i] & (bal_i[i] ^ val_n_s[i]));
    end
  end

  assign cout_o = carry_s[WIDTH];

endmodule

// File: rtl/esquema_final.sv
// esquema_final
// ATM session controller: card insert, PIN check with limited retries,
// withdrawal through a debit adder, inactivity timeout and card eject.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   PIN0..PIN3                 entered PIN (PIN0 LSB)
//   COD0..COD3, COD4           card code (COD0 LSB), account-active flag
//   ENABLE                     card present
//   Seleciona, SelecionaOpcoes confirm PIN / finish, confirm withdrawal
//   VAL1..VAL4, Cin            requested amount (VAL1 LSB), adder carry-in
//   SALDO1..SALDO4             bidirectional balance bus (SALDO1 LSB)
//   Cout, saidaComparador      adder carry-out, PIN match
//   SALDOecra1..4              displayed balance
//   VALecra1/2, Valecra3, VALecra4 displayed request
//   Tempo[8:0]                 inactivity timer
//   ejetaTentativa, ejetaTempo eject causes (too many tries, timeout)
//   PAG1..PAG4                 dispensed amount (PAG1 LSB)
module esquema_final
  import esquema_final_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       PIN0, PIN1, PIN2, PIN3,
  input  logic       COD0, COD1, COD2, COD3, COD4,
  input  logic       ENABLE,
  input  logic       Seleciona,
  input  logic       SelecionaOpcoes,
  input  logic       VAL1, VAL2, VAL3, VAL4,
  input  logic       Cin,
  inout  wire        SALDO1, SALDO2, SALDO3, SALDO4,
  output logic       Cout,
  output logic       saidaComparador,
  output logic       SALDOecra1, SALDOecra2, SALDOecra3, SALDOecra4,
  output logic       VALecra1, VALecra2, Valecra3, VALecra4,
  output logic [8:0] Tempo,
  output logic       ejetaTentativa,
  output logic       ejetaTempo,
  output logic       PAG1, PAG2, PAG3, PAG4
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bal_q, bal_d;
  logic [WIDTH-1:0] pag_q, pag_d;
  logic [WIDTH-1:0] valecra_q, valecra_d;
  logic [1:0]       tries_q, tries_d;
  logic [8:0]       tempo_q, tempo_d;
  logic             ej_try_q, ej_try_d;
  logic             ej_time_q, ej_time_d;

  logic [WIDTH-1:0] pin_s, cod_s, val_s, saldo_in_s, diff_s;
  logic             key_s, drive_s;
  logic [8:0]       tempo_inc_s;

  assign pin_s      = {PIN3, PIN2, PIN1, PIN0};
  assign cod_s      = {COD3, COD2, COD1, COD0};
  assign val_s      = {VAL4, VAL3, VAL2, VAL1};
  assign saldo_in_s = {SALDO4, SALDO3, SALDO2, SALDO1};
  assign key_s      = Seleciona | SelecionaOpcoes;
  assign tempo_inc_s = sat_inc(tempo_q);

  assign saidaComparador = (pin_s == cod_s) && COD4;

  debit_adder u_debit (
    .bal_i  (bal_q),
    .val_i  (val_s),
    .cin_i  (Cin),
    .diff_o (diff_s),
    .cout_o (Cout)
  );

  // The balance bus is driven only during the single PAY cycle.
  assign drive_s = (state_q == PAY);
  assign SALDO1  = drive_s ? bal_q[0] : 1'bz;
  assign SALDO2  = drive_s ? bal_q[1] : 1'bz;
  assign SALDO3  = drive_s ? bal_q[2] : 1'bz;
  assign SALDO4  = drive_s ? bal_q[3] : 1'bz;

  assign {SALDOecra4, SALDOecra3, SALDOecra2, SALDOecra1} = bal_q;
  assign {VALecra4, Valecra3, VALecra2, VALecra1}         = valecra_q;
  assign {PAG4, PAG3, PAG2, PAG1}                         = pag_q;
  assign Tempo          = tempo_q;
  assign ejetaTentativa = ej_try_q;
  assign ejetaTempo     = ej_time_q;

  // Next-state and datapath update for the session FSM.
  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    pag_d     = pag_q;
    tries_d   = tries_q;
    tempo_d   = tempo_q;
    ej_try_d  = ej_try_q;
    ej_time_d = ej_time_q;
    if (state_q == MENU) begin
      valecra_d = val_s;
    end else begin
      valecra_d = valecra_q;
    end

    if (!ENABLE) begin
      // Card removal aborts any state; balance and last payout survive.
      state_d   = IDLE;
      tempo_d   = 9'd0;
      tries_d   = 2'd0;
      ej_try_d  = 1'b0;
      ej_time_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bal_d   = saldo_in_s;
          tries_d = 2'd0;
          tempo_d = 9'd0;
          state_d = PIN_ENTRY;
        end
        PIN_ENTRY: begin
          if (key_s) begin
            tempo_d = 9'd0;
          end else begin
            tempo_d = tempo_inc_s;
          end
          if (Seleciona) begin
            if (saidaComparador) begin
              state_d = MENU;
            end else if (tries_q == (MAX_TRIES - 2'd1)) begin
              tries_d  = tries_q + 2'd1;
              state_d  = EJECT;
              ej_try_d = 1'b1;
            end else begin
              tries_d = tries_q + 2'd1;
            end
          end else if (!key_s && (tempo_inc_s == TIMEOUT)) begin
            state_d   = EJECT;
            ej_time_d = 1'b1;
          end else begin
            state_d = PIN_ENTRY;
          end
        end
        MENU: begin
          if (key_s) begin
            tempo_d = 9'd0;
          end else begin
            tempo_d = tempo_inc_s;
          end
          if (SelecionaOpcoes) begin
            // Withdrawal only when funds cover it and something is requested.
            if (Cout && (val_s != 4'd0)) begin
              bal_d   = diff_s;
              pag_d   = val_s;
              state_d = PAY;
            end else begin
              state_d = MENU;
            end
          end else if (Seleciona) begin
            state_d = EJECT;
          end else if (tempo_inc_s == TIMEOUT) begin
            state_d   = EJECT;
            ej_time_d = 1'b1;
          end else begin
            state_d = MENU;
          end
        end
        PAY: begin
          if (key_s) begin
            tempo_d = 9'd0;
          end else begin
            tempo_d = tempo_inc_s;
          end
          state_d = MENU;
        end
        EJECT: begin
          state_d = EJECT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bal_q     <= 4'd0;
      pag_q     <= 4'd0;
      valecra_q <= 4'd0;
      tries_q   <= 2'd0;
      tempo_q   <= 9'd0;
      ej_try_q  <= 1'b0;
      ej_time_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      pag_q     <= pag_d;
      valecra_q <= valecra_d;
      tries_q   <= tries_d;
      tempo_q   <= tempo_d;
      ej_try_q  <= ej_try_d;
      ej_time_q <= ej_time_d;
    end
  end

endmodule

// File: tb/tb_esquema_final.sv
module tb_esquema_final;

  logic clk, rst;
  logic PIN0, PIN1, PIN2, PIN3;
  logic COD0, COD1, COD2, COD3, COD4;
  logic ENABLE, Seleciona, SelecionaOpcoes;
  logic VAL1, VAL2, VAL3, VAL4, Cin;
  wire  SALDO1, SALDO2, SALDO3, SALDO4;
  logic Cout, saidaComparador;
  logic SALDOecra1, SALDOecra2, SALDOecra3, SALDOecra4;
  logic VALecra1, VALecra2, Valecra3, VALecra4;
  logic [8:0] Tempo;
  logic ejetaTentativa, ejetaTempo;
  logic PAG1, PAG2, PAG3, PAG4;

  logic       tb_drv;
  logic [3:0] tb_saldo;

  assign SALDO1 = tb_drv ? tb_saldo[0] : 1'bz;
  assign SALDO2 = tb_drv ? tb_saldo[1] : 1'bz;
  assign SALDO3 = tb_drv ? tb_saldo[2] : 1'bz;
  assign SALDO4 = tb_drv ? tb_saldo[3] : 1'bz;

  logic [3:0] bus_s, ecra_s, vecra_s, pag_s;
  assign bus_s   = {SALDO4, SALDO3, SALDO2, SALDO1};
  assign ecra_s  = {SALDOecra4, SALDOecra3, SALDOecra2, SALDOecra1};
  assign vecra_s = {VALecra4, Valecra3, VALecra2, VALecra1};
  assign pag_s   = {PAG4, PAG3, PAG2, PAG1};

  esquema_final dut (
    .clk(clk), .rst(rst),
    .PIN0(PIN0), .PIN1(PIN1), .PIN2(PIN2), .PIN3(PIN3),
    .COD0(COD0), .COD1(COD1), .COD2(COD2), .COD3(COD3), .COD4(COD4),
    .ENABLE(ENABLE), .Seleciona(Seleciona), .SelecionaOpcoes(SelecionaOpcoes),
    .VAL1(VAL1), .VAL2(VAL2), .VAL3(VAL3), .VAL4(VAL4), .Cin(Cin),
    .SALDO1(SALDO1), .SALDO2(SALDO2), .SALDO3(SALDO3), .SALDO4(SALDO4),
    .Cout(Cout), .saidaComparador(saidaComparador),
    .SALDOecra1(SALDOecra1), .SALDOecra2(SALDOecra2),
    .SALDOecra3(SALDOecra3), .SALDOecra4(SALDOecra4),
    .VALecra1(VALecra1), .VALecra2(VALecra2), .Valecra3(Valecra3), .VALecra4(VALecra4),
    .Tempo(Tempo), .ejetaTentativa(ejetaTentativa), .ejetaTempo(ejetaTempo),
    .PAG1(PAG1), .PAG2(PAG2), .PAG3(PAG3), .PAG4(PAG4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: account balance and last payout as plain numbers.
  int m_bal;
  int m_pag;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pin(input logic [3:0] p);
    {PIN3, PIN2, PIN1, PIN0} = p;
  endtask

  task automatic set_cod(input logic [3:0] c, input logic act);
    {COD3, COD2, COD1, COD0} = c;
    COD4 = act;
  endtask

  task automatic set_val(input logic [3:0] v);
    {VAL4, VAL3, VAL2, VAL1} = v;
  endtask

  // Insert card with balance b and enter the correct PIN; ends in MENU.
  task automatic open_session(input logic [3:0] b);
    tb_drv = 1'b1; tb_saldo = b; ENABLE = 1'b1;
    tick();
    tb_drv = 1'b0;
    m_bal = int'(b);
    set_pin(4'h5); set_cod(4'h5, 1'b1);
    Seleciona = 1'b1;
    tick();
    Seleciona = 1'b0;
  endtask

  task automatic close_session();
    ENABLE = 1'b0;
    tick();
  endtask

  logic [3:0] v;
  logic       ok;
  int         t_hold;

  initial begin
    rst = 1'b1; ENABLE = 1'b0; Seleciona = 1'b0; SelecionaOpcoes = 1'b0;
    Cin = 1'b1; tb_drv = 1'b0; tb_saldo = 4'h0;
    set_pin(4'h0); set_cod(4'h0, 1'b0); set_val(4'h0);
    m_bal = 0; m_pag = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_ecra", int'(ecra_s), 0);
    chk("rst_pag", int'(pag_s), 0);
    chk("rst_tempo", int'(Tempo), 0);
    chk("rst_vecra", int'(vecra_s), 0);
    chk("rst_ejt", int'(ejetaTentativa), 0);
    chk("rst_ejm", int'(ejetaTempo), 0);

    // Comparator
    set_pin(4'h5); set_cod(4'h5, 1'b1); #1;
    chk("cmp_match", int'(saidaComparador), 1);
    set_cod(4'h5, 1'b0); #1;
    chk("cmp_inactive", int'(saidaComparador), 0);
    set_pin(4'h2); set_cod(4'h5, 1'b1); #1;
    chk("cmp_mismatch", int'(saidaComparador), 0);

    // Card insert with SALDO = F and correct PIN
    tb_drv = 1'b1; tb_saldo = 4'hF; ENABLE = 1'b1;
    #1;
    chk("idle_bus_free", int'(bus_s), 15);
    tick();
    tb_drv = 1'b0;
    m_bal = 15;
    chk("load_ecra", int'(ecra_s), 15);
    chk("load_tempo", int'(Tempo), 0);
    tick();
    chk("pin_tempo_inc", int'(Tempo), 1);
    set_pin(4'h5); Seleciona = 1'b1;
    tick();
    Seleciona = 1'b0;
    chk("menu_tempo_clr", int'(Tempo), 0);
    chk("menu_ecra", int'(ecra_s), 15);

    // Withdraw 4 from F
    set_val(4'h4); Cin = 1'b1; SelecionaOpcoes = 1'b1; #1;
    chk("w4_cout", int'(Cout), 1);
    tick();
    SelecionaOpcoes = 1'b0;
    m_bal = 11; m_pag = 4;
    chk("w4_pag", int'(pag_s), 4);
    chk("w4_ecra", int'(ecra_s), 11);
    chk("w4_bus", int'(bus_s), 11);
    tick();
    chk("w4_back_menu_tempo", int'(Tempo), 1);

    // Random withdrawals against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      v = 4'($urandom_range(0, 15));
      set_val(v); Cin = 1'b1; SelecionaOpcoes = 1'b1; #1;
      chk("rnd_cout", int'(Cout), (int'(v) <= m_bal) ? 1 : 0);
      ok = (int'(v) <= m_bal) && (v != 4'h0);
      tick();
      SelecionaOpcoes = 1'b0;
      chk("rnd_vecra", int'(vecra_s), int'(v));
      if (ok) begin
        m_bal = m_bal - int'(v);
        m_pag = int'(v);
        chk("rnd_pay_bus", int'(bus_s), m_bal);
        tick();
      end
      chk("rnd_ecra", int'(ecra_s), m_bal);
      chk("rnd_pag", int'(pag_s), m_pag);
    end

    // Finish session: eject without cause flags; balance and PAG retained
    Seleciona = 1'b1;
    tick();
    Seleciona = 1'b0;
    chk("fin_ejt", int'(ejetaTentativa), 0);
    chk("fin_ejm", int'(ejetaTempo), 0);
    t_hold = int'(Tempo);
    tick(); tick();
    chk("eject_tempo_hold", int'(Tempo), t_hold);
    close_session();
    chk("idle_bal_kept", int'(ecra_s), m_bal);
    chk("idle_pag_kept", int'(pag_s), m_pag);
    chk("idle_tempo_clr", int'(Tempo), 0);

    // Insufficient funds: bal 3, request 4
    open_session(4'h3);
    set_val(4'h4); SelecionaOpcoes = 1'b1; #1;
    chk("nf_cout", int'(Cout), 0);
    tick();
    SelecionaOpcoes = 1'b0;
    chk("nf_bal", int'(ecra_s), 3);
    chk("nf_pag", int'(pag_s), m_pag);
    // Still in MENU: a valid request is honoured
    set_val(4'h1); SelecionaOpcoes = 1'b1;
    tick();
    SelecionaOpcoes = 1'b0;
    m_bal = 2; m_pag = 1;
    chk("nf_then_ok_bal", int'(ecra_s), 2);
    chk("nf_then_ok_pag", int'(pag_s), 1);
    tick();
    close_session();

    // Three wrong PINs
    tb_drv = 1'b1; tb_saldo = 4'($urandom_range(0, 15)); ENABLE = 1'b1;
    tick();
    tb_drv = 1'b0;
    m_bal = int'(tb_saldo);
    set_pin(4'h2); set_cod(4'h5, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      Seleciona = 1'b1;
      tick();
      Seleciona = 1'b0;
      chk("tries_eject", int'(ejetaTentativa), (k == 3) ? 1 : 0);
    end
    tick(); tick();
    chk("tries_hold", int'(ejetaTentativa), 1);
    chk("tries_bal", int'(ecra_s), m_bal);
    close_session();
    chk("tries_clear", int'(ejetaTentativa), 0);

    // Timeout, with key-press priority at the last cycle
    open_session(4'h9);
    set_val(4'h0);
    for (int k = 0; k < 510; k++) tick();
    chk("to_510", int'(Tempo), 510);
    chk("to_510_flag", int'(ejetaTempo), 0);
    SelecionaOpcoes = 1'b1;
    tick();
    SelecionaOpcoes = 1'b0;
    chk("to_prio_tempo", int'(Tempo), 0);
    chk("to_prio_flag", int'(ejetaTempo), 0);
    for (int k = 0; k < 510; k++) tick();
    chk("to_510b_flag", int'(ejetaTempo), 0);
    tick();
    chk("to_511", int'(Tempo), 511);
    chk("to_flag", int'(ejetaTempo), 1);
    set_val(4'hA);
    tick();
    chk("to_sat", int'(Tempo), 511);
    chk("eject_vecra_hold", int'(vecra_s), 0);
    close_session();
    chk("to_clear", int'(ejetaTempo), 0);

    // Reset in the middle of PAY
    open_session(4'h8);
    set_val(4'h3); SelecionaOpcoes = 1'b1;
    tick();
    SelecionaOpcoes = 1'b0;
    chk("pre_rst_pay_bus", int'(bus_s), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ecra", int'(ecra_s), 0);
    chk("mid_rst_pag", int'(pag_s), 0);
    chk("mid_rst_tempo", int'(Tempo), 0);
    chk("mid_rst_vecra", int'(vecra_s), 0);
    chk("mid_rst_flags", int'({ejetaTentativa, ejetaTempo}), 0);
    tick();
    rst = 1'b0;
    ENABLE = 1'b0;
    tick();
    chk("post_rst_ecra", int'(ecra_s), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/esquema_final.md
ESQUEMA_FINAL -- requirements
Module: esquema_final

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-002 SHALL have PIN0..PIN3 (in, 4 x 1): entered PIN, PIN0 = LSB.
REQ-003 SHALL have COD0..COD4 (in, 5 x 1): COD0..COD3 = stored card code (COD0 LSB); COD4 = account-active flag.
REQ-004 SHALL have ENABLE (in, 1): card present.
REQ-005 SHALL have Seleciona (in, 1): confirm PIN / finish session; SelecionaOpcoes (in, 1): confirm withdrawal.
REQ-006 SHALL have VAL1..VAL4 (in, 4 x 1): requested amount, VAL1 = LSB; Cin (in, 1): debit-adder carry-in.
REQ-007 SHALL have SALDO1..SALDO4 (inout, 4 x 1): balance bus, SALDO1 = LSB.
REQ-008 SHALL have Cout (out, 1): debit-adder carry-out; saidaComparador (out, 1): PIN match.
REQ-009 SHALL have SALDOecra1..SALDOecra4 (out, 4 x 1): displayed balance; VALecra1, VALecra2, Valecra3, VALecra4 (out, 4 x 1): displayed request (exact port spellings).
REQ-010 SHALL have Tempo (out, 9): inactivity timer; ejetaTentativa, ejetaTempo (out, 1 each): card-eject causes; PAG1..PAG4 (out, 4 x 1): dispensed amount, PAG1 = LSB.

Function
REQ-011 saidaComparador SHALL be combinational: 1 iff PIN[3:0] == COD[3:0] and COD4 == 1.
REQ-012 Debit adder SHALL be combinational: {Cout, diff[3:0]} = bal + ~VAL + Cin (5-bit result); with Cin = 1, Cout = 1 iff bal >= VAL.
REQ-013 FSM states SHALL be IDLE, PIN_ENTRY, MENU, PAY, EJECT.
REQ-014 IDLE: DUT SHALL not drive SALDO (high-Z); on ENABLE = 1, bal <= SALDO bus, tries <= 0, Tempo <= 0, go to PIN_ENTRY.
REQ-015 PIN_ENTRY: on Seleciona = 1 with saidaComparador = 1, go to MENU; with mismatch, tries += 1; third mismatch SHALL go to EJECT and set ejetaTentativa.
REQ-016 MENU: on SelecionaOpcoes = 1 with Cout = 1 and VAL != 0, bal <= diff, PAG <= VAL, go to PAY; otherwise bal and PAG SHALL be unchanged and the state SHALL remain MENU.
REQ-017 MENU: on Seleciona = 1 (with SelecionaOpcoes = 0), go to EJECT with both eject flags 0; simultaneous presses SHALL give SelecionaOpcoes priority.
REQ-018 PAY: lasts exactly one cycle, DUT SHALL drive SALDO = bal, then return to MENU.
REQ-019 Tempo SHALL increment every cycle in PIN_ENTRY/MENU/PAY, clear on any Seleciona or SelecionaOpcoes press, and saturate at 511.
REQ-020 Tempo reaching 511 SHALL move to EJECT and set ejetaTempo; a simultaneous key press in that cycle SHALL take priority (timer clears, no eject).
REQ-021 EJECT: eject flags SHALL hold until ENABLE = 0.
REQ-022 ENABLE = 0 in any state SHALL return to IDLE next edge, clearing Tempo, tries and eject flags; bal and PAG SHALL be retained.
REQ-023 SALDOecra SHALL always equal registered bal; VALecra SHALL register VAL every cycle while in MENU and hold otherwise.

Reset
REQ-024 rst SHALL force state IDLE; bal, tries, Tempo, PAG, VALecra, ejetaTentativa and ejetaTempo to 0; SALDO to high-Z.
REQ-025 Reset SHALL take effect immediately, including mid-session or mid-PAY, with no partial debit applied.

Structure
REQ-026 Shared package esquema_final_pkg SHALL hold the state enum, MAX_TRIES = 3, TIMEOUT = 511 and WIDTH = 4.
REQ-027 One sub-module, debit_adder (4-bit ripple add with Cin/Cout), SHALL implement REQ-012; everything else SHALL reside in esquema_final.

Verification
REQ-028 SALDO = 4'hF, ENABLE = 1, PIN = COD[3:0] = 4'h5, COD4 = 1, Seleciona -> saidaComparador = 1, state MENU, SALDOecra = 4'hF.
REQ-029 In MENU, VAL = 4'h4, Cin = 1, SelecionaOpcoes -> Cout = 1, PAG = 4'h4, SALDO driven 4'hB for one cycle, SALDOecra = 4'hB.
REQ-030 bal = 4'h3, VAL = 4'h4, Cin = 1, SelecionaOpcoes -> Cout = 0, bal and PAG unchanged, state MENU.
REQ-031 Three Seleciona presses with PIN = 4'h2, COD[3:0] = 4'h5 -> ejetaTentativa = 1 after the third press; cleared after ENABLE = 0.
REQ-032 No key presses for 511 cycles in MENU -> Tempo = 511, ejetaTempo = 1; rst asserted mid-session -> all outputs 0, SALDO high-Z.
